nibble_serial_adder_ctrl: RTL

- Controller that performs WIDTH-bit add/subtract by sequencing one shared 4-bit ripple-carry adder slice (bit4_RCA) over WIDTH/4 cycles, least-significant nibble first.
- The carry is registered between nibbles.
- Valid/ready handshake on the input and output sides.
- Serves as the area-minimal wide adder for datapaths that tolerate multi-cycle latency.

---
 rtl/nibble_adder_pkg.sv | 12 +
 rtl/nibble_serial_adder_ctrl_rca.sv | 24 ++
 rtl/nibble_serial_adder_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial wide adder.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca.sv
// Four-bit ripple-carry adder slice; the controller reuses this single slice on every nibble.
module bit4_RCA
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic c;

  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit slice, walked LSB nibble first with a registered carry.
module nibble_serial_adder_ctrl
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("nibble_serial_adder_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_t              state, state_nxt;
  logic                accept, step;
  logic [WIDTH-1:0]    a_reg, b_reg, sum_reg, sum_shift;
  logic                carry_reg;
  logic [CNT_W-1:0]    count;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_c;

  bit4_RCA u_slice (
    .a    (a_reg[NIBBLE_W-1:0]),
    .b    (b_reg[NIBBLE_W-1:0]),
    .cin  (carry_reg),
    .s    (nib_s),
    .cout (nib_c)
  );

  // New nibble enters at the top so that after NIBBLES steps the result is aligned.
  assign sum_shift = (sum_reg >> NIBBLE_W) | (WIDTH'(nib_s) << (WIDTH - NIBBLE_W));

  // Held low during reset so nothing is accepted until the first clean cycle.
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;
  assign cout      = carry_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B and force the initial carry at capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub | cin;
      count     <= '0;
    end else if (step) begin
      sum_reg   <= sum_shift;
      a_reg     <= a_reg >> NIBBLE_W;
      b_reg     <= b_reg >> NIBBLE_W;
      carry_reg <= nib_c;
      count     <= count + 1'b1;
    end
  end

endmodule
